// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, forwarding selects
// and result-source codes used by the hazard sequencer.
package pipeline_pkg;

  typedef logic [1:0] hazard_state_t;

  localparam hazard_state_t ST_RUN      = 2'b00;
  localparam hazard_state_t ST_MEM_WAIT = 2'b01;
  localparam hazard_state_t ST_ERROR    = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the five-stage pipeline datapath and the hazard sequencer:
// register identifiers and memory handshake in, stall/flush/forward controls out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    // Datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );

    // Hazard sequencer side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
               RdM, RdW, RegWriteM, RegWriteW, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt
    );

endinterface

// File: rtl/forward_sel.sv
// Operand forwarding select for one E-stage ALU source; the M-stage result
// is newer than the W-stage one, so it wins when both match.
module forward_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
            sel = FWD_M;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer: memory-wait FSM with timeout, load-use and
// branch arbitration, forwarding selects and saturating performance counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    hazard_ctrl_if.slave    hif
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    hazard_state_t    state;
    logic [WC_W-1:0]  wc;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    logic memstall, lwstall, branch_flush;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    assign memstall = ((state == ST_RUN) && hif.MemReqM && !hif.MemReadyM)
                    || ((state == ST_MEM_WAIT) && !hif.MemReadyM)
                    || (state == ST_ERROR);

    assign lwstall = (hif.ResultSrcE == RESULT_LOAD) && (hif.RdE != 5'd0)
                   && ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));

    // A taken branch squashes the dependent instruction, so it outranks lwstall
    assign branch_flush = !rst && !memstall && hif.PCSrcE;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (memstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hif.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lwstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            wc    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hif.MemReqM && !hif.MemReadyM) begin
                        state <= ST_MEM_WAIT;
                        wc    <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (hif.MemReadyM) begin
                        state <= ST_RUN;
                        wc    <= '0;
                    end else if (wc == WC_LAST) begin
                        state <= ST_ERROR;
                    end else begin
                        wc <= wc + WC_W'(1);
                    end
                end
                ST_ERROR: state <= ST_ERROR;
                default: begin
                    state <= ST_RUN;
                    wc    <= '0;
                end
            endcase
        end
    end

    // Counters hold at all-ones and freeze once the memory has timed out
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != ST_ERROR) begin
            if (stall_f && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (branch_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    forward_sel u_fwd_a (
        .RsE       (hif.Rs1E),
        .RdM       (hif.RdM),
        .RdW       (hif.RdW),
        .RegWriteM (hif.RegWriteM),
        .RegWriteW (hif.RegWriteW),
        .sel       (hif.ForwardAE)
    );

    forward_sel u_fwd_b (
        .RsE       (hif.Rs2E),
        .RdM       (hif.RdM),
        .RdW       (hif.RdW),
        .RegWriteM (hif.RegWriteM),
        .RegWriteW (hif.RegWriteW),
        .sel       (hif.ForwardBE)
    );

    assign hif.StallF   = stall_f;
    assign hif.StallD   = stall_d;
    assign hif.StallE   = stall_e;
    assign hif.StallM   = stall_m;
    assign hif.FlushD   = flush_d;
    assign hif.FlushE   = flush_e;
    assign hif.FlushW   = flush_w;
    assign hif.MemErr   = (state == ST_ERROR);
    assign hif.StallCnt = stall_cnt;
    assign hif.FlushCnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters so
// timeout and saturation are reachable in a few cycles.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0; hif.RdE = 0;
        hif.ResultSrcE = 2'b00; hif.PCSrcE = 0;
        hif.RdM = 0; hif.RdW = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ctl();
        return {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                hif.FlushD, hif.FlushE, hif.FlushW};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        cycle(); cycle();
        check("rst_ctl", ctl(), 7'b0000_111);
        check("rst_scnt", hif.StallCnt, 0);
        rst = 1'b0;
        #1;
        check("idle_ctl", ctl(), 7'b0000_000);
        check("idle_err", hif.MemErr, 0);
        check("idle_fcnt", hif.FlushCnt, 0);

        // Load-use
        hif.RdE = 5; hif.ResultSrcE = 2'b01; hif.Rs1D = 5;
        #1;
        check("lw_ctl", ctl(), 7'b1100_010);
        cycle();
        clear_inputs();
        #1;
        check("lw_scnt", hif.StallCnt, 1);
        check("lw_release", ctl(), 7'b0000_000);
        hif.RdE = 0; hif.ResultSrcE = 2'b01; hif.Rs1D = 0;
        #1;
        check("lw_x0_ctl", ctl(), 7'b0000_000);
        cycle();
        check("lw_x0_scnt", hif.StallCnt, 1);
        clear_inputs();

        // Forwarding
        hif.RdM = 3; hif.RdW = 3; hif.Rs1E = 3; hif.RegWriteM = 1; hif.RegWriteW = 1;
        #1;
        check("fwd_a_m", hif.ForwardAE, 2'b10);
        hif.RegWriteM = 0;
        #1;
        check("fwd_a_w", hif.ForwardAE, 2'b01);
        hif.Rs2E = 0; hif.RdW = 0;
        #1;
        check("fwd_b_x0", hif.ForwardBE, 2'b00);
        check("fwd_a_rf", hif.ForwardAE, 2'b00);
        hif.Rs2E = 7; hif.RdM = 7; hif.RegWriteM = 1;
        #1;
        check("fwd_b_m", hif.ForwardBE, 2'b10);
        clear_inputs();

        // Branch with simultaneous load-use
        hif.RdE = 9; hif.ResultSrcE = 2'b01; hif.Rs2D = 9; hif.PCSrcE = 1;
        #1;
        check("br_lw_ctl", ctl(), 7'b0000_110);
        cycle();
        clear_inputs();
        #1;
        check("br_fcnt", hif.FlushCnt, 1);
        check("br_scnt", hif.StallCnt, 1);

        // Three-cycle memory wait with a branch presented throughout
        hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_ctl%0d", i), ctl(), 7'b1111_001);
            cycle();
        end
        hif.MemReadyM = 1;
        #1;
        check("mw_done_ctl", ctl(), 7'b0000_110);
        cycle();
        hif.PCSrcE = 0; hif.MemReqM = 0; hif.MemReadyM = 0;
        #1;
        check("mw_scnt", hif.StallCnt, 4);
        check("mw_fcnt", hif.FlushCnt, 2);
        check("mw_run", ctl(), 7'b0000_000);

        // Zero-wait access
        hif.MemReqM = 1; hif.MemReadyM = 1;
        #1;
        check("zw_ctl", ctl(), 7'b0000_000);
        cycle();
        check("zw_run", hif.StallCnt, 4);

        // Timeout
        hif.MemReadyM = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            check($sformatf("to_stall%0d", i), hif.StallF, 1);
            check($sformatf("to_err%0d", i), hif.MemErr, 0);
            cycle();
        end
        check("to_err", hif.MemErr, 1);
        check("to_scnt", hif.StallCnt, 8);
        hif.MemReadyM = 1; hif.PCSrcE = 1;
        #1;
        check("to_hold_ctl", ctl(), 7'b1111_001);
        cycle();
        check("to_frozen_scnt", hif.StallCnt, 8);
        check("to_frozen_fcnt", hif.FlushCnt, 2);
        rst = 1'b1;
        #1;
        check("to_rst_ctl", ctl(), 7'b0000_111);
        cycle();
        rst = 1'b0;
        clear_inputs();
        #1;
        check("to_rst_err", hif.MemErr, 0);
        check("to_rst_scnt", hif.StallCnt, 0);
        check("to_rst_fcnt", hif.FlushCnt, 0);
        check("to_rst_run", ctl(), 7'b0000_000);

        // Reset mid-wait with memory still not ready
        hif.MemReqM = 1; hif.MemReadyM = 0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        hif.MemReqM = 0;
        #1;
        check("midrst_run", ctl(), 7'b0000_000);
        check("midrst_scnt", hif.StallCnt, 0);

        // Saturation
        hif.RdE = 12; hif.ResultSrcE = 2'b01; hif.Rs1D = 12;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_scnt", hif.StallCnt, 15);
        clear_inputs();
        hif.PCSrcE = 1;
        for (int i = 0; i < 20; i++) cycle();
        check("sat_fcnt", hif.FlushCnt, 15);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
